// File: rtl/readout_deser_if.sv
// Downstream host-FIFO handshake carrying the tagged 32-bit readout words.
interface readout_deser_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/readout_deser.sv
// Deserialises per-column ADC lanes into tagged samples and streams them,
// one column word per cycle, from a single-entry hold buffer.
module readout_deser #(
    parameter int NUM_ADC_BITS = 12,
    parameter int NUM_COL      = 20,
    parameter int SAMPLE_DLY   = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic                TX_CLK,
    input  logic                rst,
    input  logic                ADC_DATA_VALID,
    input  logic                SET_ROW,
    input  logic [8:0]          ROWADD,
    input  logic                PIXLEFTBUCK_SEL,
    input  logic [NUM_COL-1:0]  DOUT,
    readout_deser_if.master     fifo,
    output logic                row_done,
    output logic                ovf_err,
    output logic                sync_err
);
    localparam int BW = (NUM_ADC_BITS > 1) ? $clog2(NUM_ADC_BITS) : 1;
    localparam int CW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_ADC_BITS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COL - 1);
    localparam logic [3:0]    DLY_LOAD = (SAMPLE_DLY > 0) ? 4'(SAMPLE_DLY - 1) : 4'd0;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic                    v_q, s_q, v_rise, s_rise;
    logic                    dly_busy;
    logic [3:0]              dly_cnt;
    logic                    sample, resync, set_done;
    logic [BW-1:0]           bit_cnt;
    logic [NUM_ADC_BITS-1:0] lane_sr [NUM_COL];
    logic [NUM_ADC_BITS-1:0] hold    [NUM_COL];
    logic [8:0]              tag_row, hold_row;
    logic                    tag_buck, hold_buck;
    logic [CW-1:0]           col_idx;
    logic                    load_hold, accept, last_accept, ovf_set;

    assign v_rise = ADC_DATA_VALID & ~v_q;
    assign s_rise = SET_ROW & ~s_q;
    assign resync = s_rise & (bit_cnt != '0);
    // A pending delay owns the sample point; new edges are ignored until it expires.
    assign sample = ~resync & (dly_busy ? (dly_cnt == '0) : (v_rise & (SAMPLE_DLY == 0)));

    always_ff @(posedge TX_CLK) begin
        if (rst) begin
            v_q      <= 1'b0;
            s_q      <= 1'b0;
            dly_busy <= 1'b0;
            dly_cnt  <= '0;
            bit_cnt  <= '0;
            set_done <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            v_q      <= ADC_DATA_VALID;
            s_q      <= SET_ROW;
            set_done <= sample && (bit_cnt == LAST_BIT);
            if (resync) begin
                dly_busy <= 1'b0;
                bit_cnt  <= '0;
                sync_err <= 1'b1;
            end else begin
                if (dly_busy) begin
                    if (dly_cnt == '0) dly_busy <= 1'b0;
                    else               dly_cnt  <= dly_cnt - 4'd1;
                end else if (v_rise && (SAMPLE_DLY != 0)) begin
                    dly_busy <= 1'b1;
                    dly_cnt  <= DLY_LOAD;
                end
                if (sample) bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge TX_CLK) begin
        if (sample) begin
            for (int unsigned k = 0; k < NUM_COL; k++) begin
                if (MSB_FIRST != 0) lane_sr[k] <= NUM_ADC_BITS'({lane_sr[k], DOUT[k]});
                else                lane_sr[k] <= NUM_ADC_BITS'({DOUT[k], lane_sr[k]} >> 1);
            end
            if (bit_cnt == '0) begin
                tag_row  <= ROWADD;
                tag_buck <= PIXLEFTBUCK_SEL;
            end
        end
        if (load_hold) begin
            hold      <= lane_sr;
            hold_row  <= tag_row;
            hold_buck <= tag_buck;
        end
    end

    always_ff @(posedge TX_CLK) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The hold buffer is full exactly while in DRAIN; a set completing on the
    // final accept reloads it without passing through IDLE.
    always_comb begin
        state_nxt   = state;
        fifo.valid  = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        load_hold   = 1'b0;
        ovf_set     = 1'b0;
        case (state)
            IDLE: begin
                if (set_done) begin
                    load_hold = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                fifo.valid  = 1'b1;
                accept      = fifo.ready;
                last_accept = fifo.ready && (col_idx == LAST_COL);
                if (last_accept) begin
                    if (set_done) load_hold = 1'b1;
                    else          state_nxt = IDLE;
                end else if (set_done) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge TX_CLK) begin
        if (rst) begin
            col_idx  <= '0;
            row_done <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            row_done <= last_accept;
            if (ovf_set) ovf_err <= 1'b1;
            if (load_hold || last_accept) col_idx <= '0;
            else if (accept)              col_idx <= col_idx + 1'b1;
        end
    end

    assign fifo.data = (state == DRAIN)
                     ? {hold_buck, hold_row, 6'(col_idx), 16'(hold[col_idx])}
                     : '0;
endmodule

// File: tb/tb_readout_deser.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_readout_deser;
    logic        TX_CLK = 1'b0;
    logic        rst;
    logic        ADC_DATA_VALID, SET_ROW, PIXLEFTBUCK_SEL;
    logic [8:0]  ROWADD;
    logic [19:0] DOUT;
    logic        rdy_val, bp_mode, tog, ready;
    logic        rd_m, ovf_m, sync_m, rd_l, ovf_l, sync_l;

    logic [11:0] samp [20];
    logic [31:0] got_m [$];
    logic [31:0] got_l [$];
    int          rd_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        stall_m  = 1'b0;
    logic [31:0] stall_data;

    always #5 TX_CLK = ~TX_CLK;

    readout_deser_if if_m ();
    readout_deser_if if_l ();
    assign ready      = bp_mode ? tog : rdy_val;
    assign if_m.ready = ready;
    assign if_l.ready = ready;

    readout_deser #(.NUM_ADC_BITS(12), .NUM_COL(20), .SAMPLE_DLY(1), .MSB_FIRST(1)) dut_m (
        .TX_CLK(TX_CLK), .rst(rst), .ADC_DATA_VALID(ADC_DATA_VALID), .SET_ROW(SET_ROW),
        .ROWADD(ROWADD), .PIXLEFTBUCK_SEL(PIXLEFTBUCK_SEL), .DOUT(DOUT), .fifo(if_m),
        .row_done(rd_m), .ovf_err(ovf_m), .sync_err(sync_m));

    readout_deser #(.NUM_ADC_BITS(12), .NUM_COL(20), .SAMPLE_DLY(1), .MSB_FIRST(0)) dut_l (
        .TX_CLK(TX_CLK), .rst(rst), .ADC_DATA_VALID(ADC_DATA_VALID), .SET_ROW(SET_ROW),
        .ROWADD(ROWADD), .PIXLEFTBUCK_SEL(PIXLEFTBUCK_SEL), .DOUT(DOUT), .fifo(if_l),
        .row_done(rd_l), .ovf_err(ovf_l), .sync_err(sync_l));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic b, input logic [8:0] r, input int c,
                                             input logic [11:0] s);
        return {b, r, 6'(c), 4'h0, s};
    endfunction

    function automatic logic [11:0] rev12(input logic [11:0] s);
        logic [11:0] r;
        for (int i = 0; i < 12; i++) r[i] = s[11 - i];
        return r;
    endfunction

    // Words are taken where the host would accept them; data must hold across stalls.
    always @(negedge TX_CLK) begin
        if (!rst) begin
            if (if_m.valid && ready) got_m.push_back(if_m.data);
            if (if_l.valid && ready) got_l.push_back(if_l.data);
            if (rd_m) rd_cnt++;
            if (stall_m) begin
                check("stall_valid", 32'(if_m.valid), 32'd1);
                check("stall_data", if_m.data, stall_data);
            end
            stall_m    = if_m.valid && !ready;
            stall_data = if_m.data;
        end else begin
            stall_m = 1'b0;
        end
    end

    task automatic tick();
        @(posedge TX_CLK);
        #1;
        tog = ~tog;
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 20; k++) DOUT[k] = samp[k][11 - i];
            ADC_DATA_VALID = 1'b1;
            tick();
            tick();
            ADC_DATA_VALID = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic wait_words(input int n, input string tag);
        int budget = 300;
        while ((got_m.size() < n || got_l.size() < n) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check(tag, 32'(got_m.size()), 32'(n));
        repeat (6) tick();
    endtask

    task automatic verify(input string tag, input logic b, input logic [8:0] r);
        check({tag, "_count_msb"}, 32'(got_m.size()), 32'd20);
        check({tag, "_count_lsb"}, 32'(got_l.size()), 32'd20);
        for (int k = 0; k < 20; k++) begin
            if (k < got_m.size()) check({tag, "_msb"}, got_m[k], exp_word(b, r, k, samp[k]));
            if (k < got_l.size()) check({tag, "_lsb"}, got_l[k], exp_word(b, r, k, rev12(samp[k])));
        end
        got_m.delete();
        got_l.delete();
    endtask

    initial begin
        int budget;
        rst = 1'b1; ADC_DATA_VALID = 1'b0; SET_ROW = 1'b0; ROWADD = '0;
        PIXLEFTBUCK_SEL = 1'b0; DOUT = '0; rdy_val = 1'b1; bp_mode = 1'b0; tog = 1'b0;
        rd_cnt = 0;
        repeat (3) tick();
        check("rst_valid", 32'(if_m.valid), 32'd0);
        check("rst_data", if_m.data, 32'd0);
        check("rst_row_done", 32'(rd_m), 32'd0);
        check("rst_ovf", 32'(ovf_m), 32'd0);
        check("rst_sync", 32'(sync_m), 32'd0);
        rst = 1'b0;
        tick();

        // nominal: word 0 of the MSB instance is 32'h8140_0100
        for (int k = 0; k < 20; k++) samp[k] = 12'h100 + 12'(k);
        ROWADD = 9'd5; PIXLEFTBUCK_SEL = 1'b1;
        send_bits(12);
        wait_words(20, "nom_timeout");
        verify("nom", 1'b1, 9'd5);
        check("nom_row_done", 32'(rd_cnt), 32'd1);
        check("nom_ovf", 32'({ovf_m, ovf_l}), 32'd0);
        check("nom_sync", 32'({sync_m, sync_l}), 32'd0);

        // backpressure: ready alternates every cycle
        rd_cnt = 0;
        for (int k = 0; k < 20; k++) samp[k] = 12'hF00 - 12'(k);
        ROWADD = 9'h1A3; PIXLEFTBUCK_SEL = 1'b0; bp_mode = 1'b1;
        send_bits(12);
        wait_words(20, "bp_timeout");
        bp_mode = 1'b0;
        verify("bp", 1'b0, 9'h1A3);
        check("bp_row_done", 32'(rd_cnt), 32'd1);

        // overrun: second set completes while the first is still held
        rd_cnt = 0; rdy_val = 1'b0;
        for (int k = 0; k < 20; k++) samp[k] = 12'h5A0 + 12'(k);
        ROWADD = 9'd300; PIXLEFTBUCK_SEL = 1'b1;
        send_bits(12);
        for (int k = 0; k < 20; k++) samp[k] = samp[k] ^ 12'hFFF;
        ROWADD = 9'd301;
        send_bits(12);
        repeat (3) tick();
        check("ovr_ovf_msb", 32'(ovf_m), 32'd1);
        check("ovr_ovf_lsb", 32'(ovf_l), 32'd1);
        check("ovr_none_yet", 32'(got_m.size()), 32'd0);
        for (int k = 0; k < 20; k++) samp[k] = samp[k] ^ 12'hFFF;
        rdy_val = 1'b1;
        wait_words(20, "ovr_timeout");
        verify("ovr", 1'b1, 9'd300);
        check("ovr_row_done", 32'(rd_cnt), 32'd1);

        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();

        // resync: 5 partial bits, SET_ROW edge, then a full set on row 4
        rd_cnt = 0;
        for (int k = 0; k < 20; k++) samp[k] = 12'h3C0 + 12'(k);
        ROWADD = 9'd3; PIXLEFTBUCK_SEL = 1'b0;
        send_bits(5);
        SET_ROW = 1'b1; tick(); SET_ROW = 1'b0; tick();
        ROWADD = 9'd4; PIXLEFTBUCK_SEL = 1'b1;
        send_bits(12);
        wait_words(20, "rsy_timeout");
        verify("rsy", 1'b1, 9'd4);
        check("rsy_sync_msb", 32'(sync_m), 32'd1);
        check("rsy_sync_lsb", 32'(sync_l), 32'd1);
        check("rsy_ovf", 32'(ovf_m), 32'd0);
        check("rsy_row_done", 32'(rd_cnt), 32'd1);

        // reset after the 7th accepted word, then a clean set
        for (int k = 0; k < 20; k++) samp[k] = 12'h0F0 + 12'(k);
        ROWADD = 9'h155; PIXLEFTBUCK_SEL = 1'b0;
        send_bits(12);
        budget = 100;
        while (got_m.size() < 7 && budget > 0) begin
            tick();
            budget--;
        end
        rst = 1'b1;
        tick();
        check("mid_count", 32'(got_m.size()), 32'd7);
        check("mid_valid_msb", 32'(if_m.valid), 32'd0);
        check("mid_valid_lsb", 32'(if_l.valid), 32'd0);
        check("mid_sync", 32'(sync_m), 32'd0);
        check("mid_ovf", 32'(ovf_m), 32'd0);
        rst = 1'b0;
        tick();
        got_m.delete();
        got_l.delete();
        rd_cnt = 0;
        for (int k = 0; k < 20; k++) samp[k] = 12'h7E0 + 12'(k);
        ROWADD = 9'h0AA; PIXLEFTBUCK_SEL = 1'b1;
        send_bits(12);
        wait_words(20, "post_timeout");
        verify("post", 1'b1, 9'h0AA);
        check("post_row_done", 32'(rd_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
